// File: rtl/soc_bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package soc_bram_arb_pkg;

  // Identifies a bus master; also the encoding of the grant / last-grant register.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Active-low byte mask with every lane disabled: the BRAM's idle mask.
  localparam logic [3:0] WMSK_NONE = 4'hF;

  // Round-robin pick: on a tie the port that did not win last time gets it.
  function automatic port_e rr_pick(input logic elig_a, input logic elig_b, input port_e last);
    if (elig_a && elig_b) begin
      return (last == PORT_A) ? PORT_B : PORT_A;
    end else if (elig_a) begin
      return PORT_A;
    end else begin
      return PORT_B;
    end
  endfunction

endpackage

// File: rtl/soc_bram_arb.sv
// Round-robin arbiter letting two bus masters share one single-port BRAM.
// Each access is a fixed ACCESS (BRAM driven) + ACK (data returned) pair of cycles.
module soc_bram_arb
  import soc_bram_arb_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  // port A
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  input  logic [3:0]    a_wmsk,
  input  logic          a_we,
  input  logic          a_cyc,
  output logic          a_ack,
  output logic [31:0]   a_rdata,
  // port B
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  input  logic [3:0]    b_wmsk,
  input  logic          b_we,
  input  logic          b_cyc,
  output logic          b_ack,
  output logic [31:0]   b_rdata,
  // BRAM side
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wmsk,
  output logic          ram_we,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  state_e state_q, state_d;
  // The current grant doubles as the round-robin "last" record: it is only
  // updated on entry to ACCESS, so it always names the most recent winner.
  port_e  grant_q, grant_d;

  logic elig_a;
  logic elig_b;

  // A port is eligible when requesting and not the one being acked right now.
  always_comb begin
    elig_a = a_cyc && !(state_q == ST_ACK && grant_q == PORT_A);
    elig_b = b_cyc && !(state_q == ST_ACK && grant_q == PORT_B);
  end

  // State and grant registers; reset parks in IDLE with B as last winner so A wins the first tie.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= PORT_B;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (elig_a || elig_b) begin
          state_d = ST_ACCESS;
          grant_d = rr_pick(elig_a, elig_b, grant_q);
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // Only the other port can be eligible here, giving back-to-back service.
        if (elig_a || elig_b) begin
          state_d = ST_ACCESS;
          grant_d = rr_pick(elig_a, elig_b, grant_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // BRAM drive during ACCESS; write is killed by a coincident reset.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmsk  = WMSK_NONE;
    ram_we    = 1'b0;
    if (state_q == ST_ACCESS) begin
      if (grant_q == PORT_A) begin
        ram_addr  = a_addr;
        ram_wdata = a_wdata;
        ram_wmsk  = a_wmsk;
        ram_we    = a_we & ~rst;
      end else begin
        ram_addr  = b_addr;
        ram_wdata = b_wdata;
        ram_wmsk  = b_wmsk;
        ram_we    = b_we & ~rst;
      end
    end
  end

  // Ack and read data to the granted port in ACK; the other rdata is held at 0 for OR-combining.
  always_comb begin
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    a_rdata = '0;
    b_rdata = '0;
    if (state_q == ST_ACK && !rst) begin
      if (grant_q == PORT_A) begin
        a_ack   = 1'b1;
        a_rdata = ram_rdata;
      end else begin
        b_ack   = 1'b1;
        b_rdata = ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_soc_bram_arb.sv
// Directed bench for soc_bram_arb with a behavioural single-port BRAM model.
module tb_soc_bram_arb;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;
  logic [3:0]    a_wmsk, b_wmsk;
  logic          a_we, b_we, a_cyc, b_cyc;
  logic          a_ack, b_ack;
  logic [31:0]   a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wmsk;
  logic          ram_we;
  logic [31:0]   ram_rdata;

  int total;
  int bad;

  logic [31:0] mem [0:(1<<AW)-1];

  soc_bram_arb #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_wmsk    (a_wmsk),
    .a_we      (a_we),
    .a_cyc     (a_cyc),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_wmsk    (b_wmsk),
    .b_we      (b_we),
    .b_cyc     (b_cyc),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmsk  (ram_wmsk),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM: registered read of the pre-write word, active-low byte mask.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (!ram_wmsk[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_addr = '0; a_wdata = '0; a_wmsk = 4'hF; a_we = 1'b0; a_cyc = 1'b0;
    b_addr = '0; b_wdata = '0; b_wmsk = 4'hF; b_we = 1'b0; b_cyc = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'hAAAAAAAA;
    mem[8'h30] = 32'h5A5A0F0F;
    mem[8'h40] = 32'h0A0A0A0A;
    mem[8'h50] = 32'h0B0B0B0B;

    // Reset state
    repeat (3) tick();
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wmsk", ram_wmsk, 4'hF);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    rst = 1'b0;
    tick();

    // A read of 0x10
    a_addr = 8'h10; a_cyc = 1'b1;
    tick();
    check("rd_a_access_ack", a_ack, 0);
    check("rd_a_access_addr", ram_addr, 32'h10);
    check("rd_a_access_we", ram_we, 0);
    tick();
    check("rd_a_ack", a_ack, 1);
    check("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    check("rd_a_b_ack", b_ack, 0);
    check("rd_a_b_rdata", b_rdata, 0);
    a_cyc = 1'b0;
    tick();
    check("rd_a_idle_ack", a_ack, 0);
    check("rd_a_idle_addr", ram_addr, 0);

    // B masked write to 0x20, then read back
    b_addr = 8'h20; b_wdata = 32'h11223344; b_wmsk = 4'b1010; b_we = 1'b1; b_cyc = 1'b1;
    tick();
    check("wr_b_we", ram_we, 1);
    check("wr_b_addr", ram_addr, 32'h20);
    check("wr_b_wmsk", ram_wmsk, 4'b1010);
    check("wr_b_wdata", ram_wdata, 32'h11223344);
    tick();
    check("wr_b_ack", b_ack, 1);
    check("wr_b_a_ack", a_ack, 0);
    check("wr_b_prewrite", b_rdata, 32'hAAAAAAAA);
    b_cyc = 1'b0; b_we = 1'b0; b_wmsk = 4'hF;
    tick();
    b_cyc = 1'b1;
    tick();
    tick();
    check("rb_b_ack", b_ack, 1);
    check("rb_b_rdata", b_rdata, 32'hAA22AA44);
    b_cyc = 1'b0;
    tick();

    // Simultaneous requests straight out of reset: A at n+2, B at n+4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_addr = 8'h10; a_cyc = 1'b1;
    b_addr = 8'h20; b_cyc = 1'b1;
    tick();
    check("tie1_n1_addr", ram_addr, 32'h10);
    check("tie1_n1_acks", {a_ack, b_ack}, 0);
    tick();
    check("tie1_n2_a_ack", a_ack, 1);
    check("tie1_n2_b_ack", b_ack, 0);
    check("tie1_n2_a_rdata", a_rdata, 32'hDEADBEEF);
    a_cyc = 1'b0;
    tick();
    check("tie1_n3_addr", ram_addr, 32'h20);
    check("tie1_n3_acks", {a_ack, b_ack}, 0);
    tick();
    check("tie1_n4_b_ack", b_ack, 1);
    check("tie1_n4_a_ack", a_ack, 0);
    check("tie1_n4_b_rdata", b_rdata, 32'hAA22AA44);
    b_cyc = 1'b0;
    tick();

    // A alone, so A is last; the next tie must go to B
    a_cyc = 1'b1;
    tick();
    tick();
    check("solo_a_ack", a_ack, 1);
    a_cyc = 1'b0;
    tick();
    a_cyc = 1'b1; b_cyc = 1'b1;
    tick();
    check("tie2_n1_addr", ram_addr, 32'h20);
    tick();
    check("tie2_n2_b_ack", b_ack, 1);
    check("tie2_n2_a_ack", a_ack, 0);
    b_cyc = 1'b0;
    tick();
    check("tie2_n3_addr", ram_addr, 32'h10);
    tick();
    check("tie2_n4_a_ack", a_ack, 1);
    check("tie2_n4_b_ack", b_ack, 0);
    a_cyc = 1'b0;
    tick();

    // Both busy for 8 transactions: A,B,A,... one ack every 2 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_addr = 8'h40; b_addr = 8'h50;
    a_cyc = 1'b1; b_cyc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("alt_a_ack_%0d", k), a_ack, (k % 4 == 2) ? 1 : 0);
      check($sformatf("alt_b_ack_%0d", k), b_ack, (k % 4 == 0) ? 1 : 0);
      check($sformatf("alt_a_rdata_%0d", k), a_rdata, (k % 4 == 2) ? 32'h0A0A0A0A : 32'h0);
      check($sformatf("alt_b_rdata_%0d", k), b_rdata, (k % 4 == 0) ? 32'h0B0B0B0B : 32'h0);
      if (k == 16) begin
        a_cyc = 1'b0; b_cyc = 1'b0;
      end
    end
    tick();

    // Reset during the ACCESS cycle of a B write to 0x30
    b_addr = 8'h30; b_wdata = 32'hFFFFFFFF; b_wmsk = 4'h0; b_we = 1'b1; b_cyc = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("rstw_ram_we", ram_we, 0);
    tick();
    check("rstw_b_ack", b_ack, 0);
    check("rstw_idle_wmsk", ram_wmsk, 4'hF);
    check("rstw_idle_addr", ram_addr, 0);
    rst = 1'b0; b_cyc = 1'b0; b_we = 1'b0; b_wmsk = 4'hF;
    tick();
    check("rstw_mem", mem[8'h30], 32'h5A5A0F0F);
    a_addr = 8'h30; a_cyc = 1'b1;
    tick();
    tick();
    check("rstw_rb_ack", a_ack, 1);
    check("rstw_rb_rdata", a_rdata, 32'h5A5A0F0F);
    a_cyc = 1'b0;
    tick();

    // Single port held busy: ack every 3 cycles, never a write
    a_addr = 8'h40; a_cyc = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("solo_ack_%0d", k), a_ack, (k % 3 == 2) ? 1 : 0);
      check($sformatf("solo_we_%0d", k), ram_we, 0);
    end
    a_cyc = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
